// File: rtl/pe_frame_driver.sv
// Host-side frame driver for the background-removal pe: a sum pass, then a removal pass, results captured for readback.
// Optional running checksum of captured result pixels, built only when PE_DRV_CHECKSUM_EN is defined.
module pe_frame_driver #(
   parameter int NUM_PIXELS = 25,
   parameter int ADDR_W     = 5,
   parameter int TIMEOUT    = 255
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Go,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [7:0]        ld_red,
   input  logic [7:0]        ld_green,
   input  logic [7:0]        ld_blue,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_red,
   output logic [7:0]        rd_green,
   output logic [7:0]        rd_blue,
   output logic [7:0]        pe_red,
   output logic [7:0]        pe_green,
   output logic [7:0]        pe_blue,
   output logic              pe_Start_Sum,
   output logic              pe_Start_BgRemoval,
   output logic              pe_Ack,
   input  logic              pe_done,
   input  logic [7:0]        pe_red_out,
   input  logic [7:0]        pe_green_out,
   input  logic [7:0]        pe_blue_out,
   output logic              Busy,
   output logic              Done,
   output logic              Error,
   output logic [15:0]       checksum
);

   typedef enum logic [3:0] {
      S_IDLE, S_SUM_ISSUE, S_SUM_WAIT, S_SUM_ACK,
      S_BG_ISSUE, S_BG_WAIT, S_BG_ACK, S_FRAME_DONE, S_ERR
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_PIXELS - 1);
   localparam logic [7:0]        TIMER_LAST = 8'(TIMEOUT - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [7:0]          timer_q, timer_d;
   logic                error_q, error_d;
   logic [23:0]         rd_q, rd_d;
   logic                capture;
   logic [23:0]         in_buf_q  [NUM_PIXELS];
   logic [23:0]         res_buf_q [NUM_PIXELS];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      timer_d = timer_q;
      error_d = error_q;
      capture = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (Go) begin
               state_d = S_SUM_ISSUE;
               idx_d   = '0;
               error_d = 1'b0;
            end
         end
         S_SUM_ISSUE: begin
            timer_d = '0;
            state_d = S_SUM_WAIT;
         end
         S_SUM_WAIT: begin
            if (pe_done) begin
               state_d = S_SUM_ACK;
            end else begin
               timer_d = timer_q + 8'd1;
               if (timer_q == TIMER_LAST) begin
                  state_d = S_ERR;
                  error_d = 1'b1;
               end
            end
         end
         // Ack is held until the pe drops done, so a slow pe never sees a second start early.
         S_SUM_ACK: begin
            if (!pe_done) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = S_BG_ISSUE;
               end else begin
                  idx_d   = idx_q + ADDR_W'(1);
                  state_d = S_SUM_ISSUE;
               end
            end
         end
         S_BG_ISSUE: begin
            timer_d = '0;
            state_d = S_BG_WAIT;
         end
         S_BG_WAIT: begin
            if (pe_done) begin
               state_d = S_BG_ACK;
               capture = 1'b1;
            end else begin
               timer_d = timer_q + 8'd1;
               if (timer_q == TIMER_LAST) begin
                  state_d = S_ERR;
                  error_d = 1'b1;
               end
            end
         end
         S_BG_ACK: begin
            if (!pe_done) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = S_FRAME_DONE;
               end else begin
                  idx_d   = idx_q + ADDR_W'(1);
                  state_d = S_BG_ISSUE;
               end
            end
         end
         S_FRAME_DONE: if (!Go) state_d = S_IDLE;
         S_ERR:        if (!Go) state_d = S_IDLE;
         default:      state_d = S_IDLE;
      endcase
   end

   always_comb begin
      Busy               = 1'b0;
      pe_Start_Sum       = (state_q == S_SUM_ISSUE);
      pe_Start_BgRemoval = (state_q == S_BG_ISSUE);
      pe_Ack             = (state_q == S_SUM_ACK) || (state_q == S_BG_ACK);
      Done               = (state_q == S_FRAME_DONE);
      Error              = error_q;
      case (state_q)
         S_SUM_ISSUE, S_SUM_WAIT, S_SUM_ACK,
         S_BG_ISSUE, S_BG_WAIT, S_BG_ACK: Busy = 1'b1;
         default:                         Busy = 1'b0;
      endcase
      {pe_red, pe_green, pe_blue} = Busy ? in_buf_q[idx_q] : 24'd0;
      rd_d = (int'(rd_addr) < NUM_PIXELS) ? res_buf_q[rd_addr] : 24'd0;
      {rd_red, rd_green, rd_blue} = rd_q;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         timer_q <= '0;
         error_q <= 1'b0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         timer_q <= timer_d;
         error_q <= error_d;
         rd_q    <= rd_d;
      end
   end

   // Buffers hold frame data only and survive reset.
   always_ff @(posedge Clk) begin
      if (ld_we && (state_q == S_IDLE) && (int'(ld_addr) < NUM_PIXELS))
         in_buf_q[ld_addr] <= {ld_red, ld_green, ld_blue};
      if (capture)
         res_buf_q[idx_q] <= {pe_red_out, pe_green_out, pe_blue_out};
   end

`ifdef PE_DRV_CHECKSUM_EN
   logic [15:0] cksum_q, cksum_d;

   always_comb begin
      cksum_d = cksum_q;
      if ((state_q == S_IDLE) && Go)
         cksum_d = '0;
      else if (capture)
         cksum_d = cksum_q + 16'(pe_red_out) + 16'(pe_green_out) + 16'(pe_blue_out);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) cksum_q <= '0;
      else        cksum_q <= cksum_d;
   end

   assign checksum = cksum_q;
`else
   assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_pe_frame_driver.sv
// Directed bench for pe_frame_driver with a behavioural pe and a per-cycle handshake/data checker.
module tb_pe_frame_driver;

   localparam int NP = 25;

   logic       Clk = 1'b0;
   logic       Reset, Go, ld_we;
   logic [4:0] ld_addr, rd_addr;
   logic [7:0] ld_red, ld_green, ld_blue;
   logic [7:0] rd_red, rd_green, rd_blue;
   logic [7:0] pe_red, pe_green, pe_blue;
   logic       pe_Start_Sum, pe_Start_BgRemoval, pe_Ack, pe_done;
   logic [7:0] pe_red_out, pe_green_out, pe_blue_out;
   logic       Busy, Done, Error;
   logic [15:0] checksum;

   pe_frame_driver #(.NUM_PIXELS(NP), .ADDR_W(5), .TIMEOUT(255)) dut (
      .Clk(Clk), .Reset(Reset), .Go(Go), .ld_we(ld_we), .ld_addr(ld_addr),
      .ld_red(ld_red), .ld_green(ld_green), .ld_blue(ld_blue), .rd_addr(rd_addr),
      .rd_red(rd_red), .rd_green(rd_green), .rd_blue(rd_blue),
      .pe_red(pe_red), .pe_green(pe_green), .pe_blue(pe_blue),
      .pe_Start_Sum(pe_Start_Sum), .pe_Start_BgRemoval(pe_Start_BgRemoval), .pe_Ack(pe_Ack),
      .pe_done(pe_done), .pe_red_out(pe_red_out), .pe_green_out(pe_green_out),
      .pe_blue_out(pe_blue_out), .Busy(Busy), .Done(Done), .Error(Error), .checksum(checksum)
   );

   always #5 Clk = ~Clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
      end
   endtask

   logic [23:0] exp_in [NP];

   // Behavioural pe: bright-red pixels are foreground and pass through, everything else becomes (10,10,10).
   function automatic logic [23:0] pe_fn(input logic [23:0] p);
      return (p[23:16] >= 8'd150) ? p : 24'h0A0A0A;
   endfunction

   function automatic int model_checksum();
      int s = 0;
      for (int i = 0; i < NP; i++) begin
         logic [23:0] r = pe_fn(exp_in[i]);
         s += int'(r[23:16]) + int'(r[15:8]) + int'(r[7:0]);
      end
      return s % 65536;
   endfunction

   // ---------------- behavioural pe ----------------
   int          resp_k   = 2;
   int          ack_drop = 2;
   int          hang_pix = -1;
   int          pm_cnt, pm_acks, pm_sum_n;
   bit          pm_busy, pm_hang, pm_bg;
   logic [23:0] pm_pix;
   logic        clr = 1'b0;

   always @(negedge Clk) begin
      if (!Reset || clr) begin
         if (!Reset) begin
            pe_done = 1'b0;
            {pe_red_out, pe_green_out, pe_blue_out} = 24'd0;
            pm_busy = 1'b0;
         end
         pm_sum_n = 0;
      end else if (pe_Start_Sum || pe_Start_BgRemoval) begin
         pm_busy = 1'b1;
         pm_cnt  = 0;
         pm_acks = 0;
         pm_bg   = pe_Start_BgRemoval;
         pm_pix  = {pe_red, pe_green, pe_blue};
         pm_hang = pe_Start_Sum && (pm_sum_n == hang_pix);
         if (pe_Start_Sum) pm_sum_n++;
      end else if (pm_busy && !pe_done) begin
         pm_cnt++;
         if (pm_cnt == resp_k && !pm_hang) begin
            pe_done = 1'b1;
            {pe_red_out, pe_green_out, pe_blue_out} = pm_bg ? pe_fn(pm_pix) : 24'hEEEEEE;
         end
      end else if (pe_done && pe_Ack) begin
         pm_acks++;
         if (pm_acks == ack_drop) begin
            pe_done = 1'b0;
            {pe_red_out, pe_green_out, pe_blue_out} = 24'd0;
            pm_busy = 1'b0;
         end
      end
   end

   // ---------------- per-cycle checker ----------------
   int c_sum, c_bg, ack_run, pix;
   int exp_ack_len = 2;
   bit prev_start;

   always @(negedge Clk) begin
      if (!Reset || clr) begin
         c_sum = 0; c_bg = 0; ack_run = 0; prev_start = 1'b0;
      end else begin
         if (pe_Start_Sum || pe_Start_BgRemoval) chk("start_pulse_width", int'(prev_start), 0);
         if (pe_Start_Sum) begin
            chk("sum_before_bg", c_bg, 0);
            c_sum++;
         end
         if (pe_Start_BgRemoval) begin
            chk("sum_pass_complete", c_sum, NP);
            c_bg++;
         end
         if (Busy) begin
            pix = (c_bg > 0) ? c_bg - 1 : c_sum - 1;
            if (pix >= 0 && pix < NP) chk("pe_rgb", int'({pe_red, pe_green, pe_blue}), int'(exp_in[pix]));
            else                      chk("pe_pixel_index", pix, NP - 1);
         end
         if (pe_Ack) ack_run++;
         else if (ack_run > 0) begin
            chk("ack_length", ack_run, exp_ack_len);
            ack_run = 0;
         end
         prev_start = pe_Start_Sum || pe_Start_BgRemoval;
      end
   end

   // ---------------- stimulus ----------------
   task automatic load(input int i, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      @(negedge Clk); #1;
      ld_we = 1'b1; ld_addr = 5'(i); ld_red = r; ld_green = g; ld_blue = b;
      exp_in[i] = {r, g, b};
      @(negedge Clk); #1;
      ld_we = 1'b0;
   endtask

   task automatic start_frame();
      @(negedge Clk); #1;
      Go = 1'b0; clr = 1'b1;
      @(negedge Clk); #1;
      clr = 1'b0; Go = 1'b1;
   endtask

   task automatic run_frame(input int budget, output int cyc);
      start_frame();
      cyc = 0;
      while (!Done && !Error && cyc < budget) begin
         @(negedge Clk); #1;
         cyc++;
      end
      chk("frame_done_seen", int'(Done), 1);
   endtask

   task automatic check_frame();
      chk("done", int'(Done), 1);
      chk("busy_after_frame", int'(Busy), 0);
      chk("error_after_frame", int'(Error), 0);
      chk("sum_pulses", c_sum, NP);
      chk("bg_pulses", c_bg, NP);
`ifdef PE_DRV_CHECKSUM_EN
      chk("checksum_model", int'(checksum), model_checksum());
`else
      chk("checksum_off", int'(checksum), 0);
`endif
   endtask

   task automatic readback();
      for (int a = 0; a < NP; a++) begin
         @(negedge Clk); #1;
         rd_addr = 5'(a);
         @(negedge Clk); #1;
         chk("rd_pixel", int'({rd_red, rd_green, rd_blue}), int'(pe_fn(exp_in[a])));
      end
   endtask

   task automatic rd_literal(input int a, input logic [23:0] exp);
      @(negedge Clk); #1;
      rd_addr = 5'(a);
      @(negedge Clk); #1;
      chk("rd_literal", int'({rd_red, rd_green, rd_blue}), int'(exp));
   endtask

   initial begin
      int cyc, nst, nbg, t0;
      Reset = 1'b0; Go = 1'b0; ld_we = 1'b0; ld_addr = '0; rd_addr = '0;
      ld_red = '0; ld_green = '0; ld_blue = '0;
      repeat (2) @(negedge Clk);
      #1;
      chk("rst_busy", int'(Busy), 0);
      chk("rst_done", int'(Done), 0);
      chk("rst_error", int'(Error), 0);
      chk("rst_start_sum", int'(pe_Start_Sum), 0);
      chk("rst_start_bg", int'(pe_Start_BgRemoval), 0);
      chk("rst_ack", int'(pe_Ack), 0);
      chk("rst_pe_rgb", int'({pe_red, pe_green, pe_blue}), 0);
      chk("rst_rd", int'({rd_red, rd_green, rd_blue}), 0);
      chk("rst_checksum", int'(checksum), 0);
      Reset = 1'b1;

      for (int i = 0; i < NP; i++) load(i, 8'd61, 8'd133, 8'd198);

      // uniform background frame, 2-cycle pe
      run_frame(400, cyc);
      chk("frame_cycles_k2", cyc, 251);
      check_frame();
      repeat (3) @(negedge Clk);
      #1;
      chk("go_held_stays_done", int'(Done), 1);
      chk("go_held_no_restart", c_sum, NP);
      readback();
      rd_literal(12, 24'h0A0A0A);
`ifdef PE_DRV_CHECKSUM_EN
      chk("checksum_750", int'(checksum), 750);
`else
      chk("checksum_tied_0", int'(checksum), 0);
`endif
      Go = 1'b0;
      @(negedge Clk); #1;
      chk("done_clears", int'(Done), 0);

      // one foreground pixel
      load(7, 8'd200, 8'd20, 8'd20);
      run_frame(400, cyc);
      chk("frame_cycles_mixed", cyc, 251);
      check_frame();
      readback();
      rd_literal(7, 24'hC81414);
      rd_literal(6, 24'h0A0A0A);
`ifdef PE_DRV_CHECKSUM_EN
      chk("checksum_960", int'(checksum), 960);
`endif

      // pe holds done five cycles past Ack
      ack_drop = 6; exp_ack_len = 6;
      run_frame(700, cyc);
      chk("frame_cycles_slow_drop", cyc, 451);
      check_frame();
      readback();
      ack_drop = 2; exp_ack_len = 2;

      // pe never answers sum pixel 4
      hang_pix = 4;
      start_frame();
      nst = 0; t0 = -1000; cyc = 0;
      while (!Error && cyc < 600) begin
         @(negedge Clk); #1;
         cyc++;
         if (pe_Start_Sum) begin
            nst++;
            if (nst == 5) t0 = cyc;
         end
      end
      chk("timeout_error", int'(Error), 1);
      chk("timeout_latency", cyc - t0, 256);
      chk("timeout_busy", int'(Busy), 0);
      chk("timeout_ack", int'(pe_Ack), 0);
      chk("timeout_no_bg", c_bg, 0);
      chk("timeout_sum_pulses", c_sum, 5);
      Go = 1'b0;
      repeat (2) @(negedge Clk);
      #1;
      chk("error_sticky_in_idle", int'(Error), 1);
      hang_pix = -1;

      // reset during BG_WAIT of pixel 3
      start_frame();
      @(negedge Clk); #1;
      chk("error_cleared_by_go", int'(Error), 0);
      nbg = 0; cyc = 0;
      while (nbg < 4 && cyc < 600) begin
         @(negedge Clk); #1;
         cyc++;
         if (pe_Start_BgRemoval) nbg++;
      end
      chk("reached_bg_pixel3", nbg, 4);
      @(posedge Clk); #2;
      Reset = 1'b0;
      #1;
      chk("arst_busy", int'(Busy), 0);
      chk("arst_ack", int'(pe_Ack), 0);
      chk("arst_start_bg", int'(pe_Start_BgRemoval), 0);
      chk("arst_done", int'(Done), 0);
      chk("arst_error", int'(Error), 0);
      chk("arst_pe_rgb", int'({pe_red, pe_green, pe_blue}), 0);
      chk("arst_rd", int'({rd_red, rd_green, rd_blue}), 0);
      chk("arst_checksum", int'(checksum), 0);
      Go = 1'b0;
      repeat (2) @(negedge Clk);
      #1;
      Reset = 1'b1;
      run_frame(400, cyc);
      chk("frame_cycles_after_reset", cyc, 251);
      check_frame();
      readback();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pe_frame_driver.md
Name: pe_frame_driver

Overview:
- Host-side driver for the background-removal processing element (pe). It is the initiator end of the pe's Start/Ack handshake.
- Holds a small input frame buffer and runs two passes over it:
  - sum pass: one Start_Sum per pixel.
  - removal pass: one Start_BgRemoval per pixel.
- Captures the pe's replaced pixels into a result buffer, which the host reads back.

Parameters:
- NUM_PIXELS, 25, pixels per frame (2..2**ADDR_W).
- ADDR_W, 5, buffer address width.
- TIMEOUT, 255, max cycles to wait for pe_done per pixel (8-bit counter).

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Go  in  1  start frame; level, sampled in IDLE.
- ld_we  in  1  write input buffer at ld_addr (ignored while Busy).
- ld_addr  in  ADDR_W  input buffer write address.
- ld_red, ld_green, ld_blue  in  8 each  pixel to store.
- rd_addr  in  ADDR_W  result buffer read address.
- rd_red, rd_green, rd_blue  out  8 each  result pixel; registered, 1-cycle latency.
- pe_red, pe_green, pe_blue  out  8 each  pixel presented to pe.
- pe_Start_Sum  out  1  one-cycle pulse, sum pass.
- pe_Start_BgRemoval  out  1  one-cycle pulse, removal pass.
- pe_Ack  out  1  acknowledge of pe completion.
- pe_done  in  1  pe is in a done state (sum-done or bg-done).
- pe_red_out, pe_green_out, pe_blue_out  in  8 each  pe result pixel.
- Busy  out  1  frame in progress.
- Done  out  1  frame complete.
- Error  out  1  pe timeout.
- checksum  out  16  see Optional Feature.

Behaviour:
- Reset low (async): state IDLE, idx=0, timer=0, all outputs 0. Buffer contents are not cleared.
- States: IDLE, SUM_ISSUE, SUM_WAIT, SUM_ACK, BG_ISSUE, BG_WAIT, BG_ACK, FRAME_DONE, ERR.
- IDLE:
  - ld_we writes in_buf[ld_addr]; writes with ld_addr >= NUM_PIXELS are dropped.
  - Go=1 -> SUM_ISSUE, idx=0, Busy=1.
- SUM_ISSUE: pe_rgb = in_buf[idx]; pe_Start_Sum=1 for exactly this cycle -> SUM_WAIT; timer=0.
- SUM_WAIT:
  - pe_done=1 -> SUM_ACK.
  - else timer++; timer==TIMEOUT -> ERR.
- SUM_ACK:
  - pe_Ack=1, held until pe_done samples 0.
  - Then: if idx==NUM_PIXELS-1, idx=0 -> BG_ISSUE; else idx++ -> SUM_ISSUE.
- BG_ISSUE / BG_WAIT: identical to the sum states, using pe_Start_BgRemoval.
- BG_ACK:
  - On entry, res_buf[idx] <= {pe_red_out, pe_green_out, pe_blue_out}, captured exactly once per pixel.
  - Same Ack/advance rule as SUM_ACK; after the last pixel -> FRAME_DONE.
- FRAME_DONE: Busy=0, Done=1; Go=0 -> IDLE (Done clears).
- ERR:
  - Busy=0, Error=1, pe_Ack=0.
  - Go=0 -> IDLE. Error stays set until the next Go rises in IDLE.
- pe_rgb holds in_buf[idx] throughout each pixel's ISSUE/WAIT/ACK; the pe sees stable data.
- Go held high after FRAME_DONE: the block stays in FRAME_DONE (no auto-restart).
- Go deasserted mid-frame: ignored; the frame completes.
- ld_we while Busy: ignored.
- rd_addr is readable in any state.
- pe_done already high in an ISSUE state: the block still enters WAIT and then ACK next cycle. No pixel is skipped.
- Sum-pass latency per pixel, with a pe that responds k cycles after start and drops done 1 cycle after Ack: k+3 cycles.

Optional Feature:
- Macro: PE_DRV_CHECKSUM_EN.
- Defined:
  - checksum clears on Go in IDLE.
  - Each BG_ACK capture adds pe_red_out+pe_green_out+pe_blue_out, mod 2**16.
  - Value is valid while Done=1.
- Undefined: checksum is tied to 0 and no accumulator logic is built.

Test Plan:
- Reset mid-frame: assert Reset low during BG_WAIT of pixel 3 -> all outputs 0 immediately. Next Go restarts from pixel 0. Input buffer intact.
- Single frame, NUM_PIXELS=25, all pixels (61,133,198); behavioural pe returns (10,10,10) for background, 2-cycle response -> exactly 25 Start_Sum pulses, then 25 Start_BgRemoval pulses, Done=1. Every rd_addr reads (10,10,10).
- Mixed frame: pixel 7 = (200,20,20) and the pe passes it through -> rd_addr=7 returns (200,20,20) one cycle later; others return 10s.
- Timeout: pe never raises pe_done on pixel 4 of the sum pass -> Error=1 after 255 wait cycles, Busy=0, no Start_BgRemoval ever issued.
- Handshake robustness: pe holds pe_done 5 cycles after Ack -> pe_Ack stays high all 5 cycles. No double capture and no skipped index.
- Checksum (PE_DRV_CHECKSUM_EN): 25 outputs of (10,10,10) -> checksum=750. Macro undefined -> checksum=0.
